// File: rtl/disp_sched_pkg.sv
// rtl/disp_sched_pkg.sv - shared types and helpers for the display page scheduler
package disp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ALERT = 2'd2
  } sched_state_e;

  localparam logic [15:0] BLANK_DEFAULT = 16'h0000;
  localparam int MAX_SRC = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } next_valid_t;

  // Round-robin search over cur+1 .. num_src-1, then 0 .. cur; cur itself is the last candidate
  function automatic next_valid_t next_valid(input logic [MAX_SRC-1:0] valid,
                                             input logic [2:0]         cur,
                                             input int                 num_src);
    next_valid_t res;
    int          cand;
    res = '0;
    // Walk from the farthest candidate back to the nearest so the nearest valid one wins
    for (int k = MAX_SRC; k >= 1; k--) begin
      if (k <= num_src) begin
        cand = (int'(cur) + k) % num_src;
        if (valid[cand]) begin
          res.found = 1'b1;
          res.idx   = 3'(cand);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/disp_dwell_timer.sv
// rtl/disp_dwell_timer.sv - loadable down-counter timing page dwell and alert hold
module disp_dwell_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expire
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Load wins over counting; the count parks at zero until reloaded
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pulses in the last counted cycle, as the count steps from 1 to 0, so that a
  // load of N places the following registered write exactly N cycles after the last one
  assign expire = (cnt_q == TW'(1));

endmodule

// File: rtl/disp_page_scheduler.sv
// rtl/disp_page_scheduler.sv - round-robin page rotation with alert preemption for the 7-seg display
module disp_page_scheduler
  import disp_sched_pkg::*;
#(
  parameter int            NUM_SRC      = 4,
  parameter int            DW           = 16,
  parameter int            DWELL_CYCLES = 20_000_000,
  parameter int            ALERT_CYCLES = 30_000_000,
  parameter logic [DW-1:0] BLANK        = DW'(BLANK_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*DW-1:0]      src_data,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC-1:0]         src_upd,
  input  logic                       alert_req,
  input  logic [DW-1:0]              alert_data,
  output logic                       alert_ack,
  output logic [DW-1:0]              disp_data,
  output logic                       disp_we,
  output logic [$clog2(NUM_SRC)-1:0] page_idx,
  output logic                       alert_active
);

  localparam int PIW     = $clog2(NUM_SRC);
  localparam int MAX_CYC = (DWELL_CYCLES > ALERT_CYCLES) ? DWELL_CYCLES : ALERT_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  sched_state_e   state_q, state_d;
  logic [DW-1:0]  disp_data_q, disp_data_d;
  logic           disp_we_q, disp_we_d;
  logic           alert_ack_q, alert_ack_d;
  logic           alert_active_q, alert_active_d;
  logic [PIW-1:0] page_idx_q, page_idx_d;
  logic [PIW-1:0] saved_q, saved_d;

  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tmr_expire;

  logic [MAX_SRC-1:0] valid_ext;
  next_valid_t        nv_first, nv_page, nv_saved;
  logic               advance;
  logic               tgt_found;
  logic [PIW-1:0]     tgt_idx;

  assign valid_ext = MAX_SRC'(src_valid);
  assign nv_first  = next_valid(valid_ext, 3'(NUM_SRC - 1), NUM_SRC);
  assign nv_page   = next_valid(valid_ext, 3'(page_idx_q), NUM_SRC);
  assign nv_saved  = next_valid(valid_ext, 3'(saved_q), NUM_SRC);

  // Decide whether the shown page changes this cycle and which page comes next
  always_comb begin
    advance   = 1'b0;
    tgt_found = 1'b0;
    tgt_idx   = page_idx_q;
    case (state_q)
      IDLE: begin
        advance   = |src_valid;
        tgt_found = nv_first.found;
        tgt_idx   = PIW'(nv_first.idx);
      end
      SHOW: begin
        advance   = tmr_expire || !src_valid[page_idx_q];
        tgt_found = nv_page.found;
        tgt_idx   = PIW'(nv_page.idx);
      end
      ALERT: begin
        advance = tmr_expire;
        if (src_valid[saved_q]) begin
          tgt_found = 1'b1;
          tgt_idx   = saved_q;
        end else begin
          tgt_found = nv_saved.found;
          tgt_idx   = PIW'(nv_saved.idx);
        end
      end
      default: ;
    endcase
  end

  // Next register values: alert entry beats a page advance, which beats a data refresh
  always_comb begin
    state_d        = state_q;
    disp_data_d    = disp_data_q;
    disp_we_d      = 1'b0;
    page_idx_d     = page_idx_q;
    alert_ack_d    = 1'b0;
    alert_active_d = alert_active_q;
    saved_d        = saved_q;
    tmr_load       = 1'b0;
    tmr_val        = '0;
    if (state_q != ALERT && alert_req) begin
      state_d        = ALERT;
      saved_d        = page_idx_q;
      disp_data_d    = alert_data;
      disp_we_d      = 1'b1;
      alert_ack_d    = 1'b1;
      alert_active_d = 1'b1;
      tmr_load       = 1'b1;
      tmr_val        = TW'(ALERT_CYCLES);
    end else if (advance) begin
      alert_active_d = 1'b0;
      disp_we_d      = 1'b1;
      tmr_load       = 1'b1;
      if (tgt_found) begin
        state_d     = SHOW;
        page_idx_d  = tgt_idx;
        disp_data_d = src_data[int'(tgt_idx)*DW +: DW];
        tmr_val     = TW'(DWELL_CYCLES);
      end else begin
        // Nothing left to show: blank the display and park the timer at zero
        state_d     = IDLE;
        disp_data_d = BLANK;
      end
    end else if (state_q == SHOW && src_upd[page_idx_q]) begin
      disp_we_d   = 1'b1;
      disp_data_d = src_data[int'(page_idx_q)*DW +: DW];
    end
  end

  // Scheduler state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      disp_data_q    <= BLANK;
      disp_we_q      <= 1'b0;
      page_idx_q     <= '0;
      alert_ack_q    <= 1'b0;
      alert_active_q <= 1'b0;
      saved_q        <= '0;
    end else begin
      state_q        <= state_d;
      disp_data_q    <= disp_data_d;
      disp_we_q      <= disp_we_d;
      page_idx_q     <= page_idx_d;
      alert_ack_q    <= alert_ack_d;
      alert_active_q <= alert_active_d;
      saved_q        <= saved_d;
    end
  end

  disp_dwell_timer #(
    .TW(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expire  (tmr_expire)
  );

  assign disp_data    = disp_data_q;
  assign disp_we      = disp_we_q;
  assign page_idx     = page_idx_q;
  assign alert_ack    = alert_ack_q;
  assign alert_active = alert_active_q;

endmodule

// File: tb/tb_disp_page_scheduler.sv
// tb/tb_disp_page_scheduler.sv - self-checking bench for disp_page_scheduler
module tb_disp_page_scheduler;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DWELL = 8;
  localparam int ALRT  = 5;

  localparam int M_IDLE  = 0;
  localparam int M_SHOW  = 1;
  localparam int M_ALERT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_upd;
  logic            alert_req;
  logic [DW-1:0]   alert_data;
  logic            alert_ack;
  logic [DW-1:0]   disp_data;
  logic            disp_we;
  logic [1:0]      page_idx;
  logic            alert_active;

  always #5 clk = ~clk;

  disp_page_scheduler #(
    .NUM_SRC     (N),
    .DW          (DW),
    .DWELL_CYCLES(DWELL),
    .ALERT_CYCLES(ALRT),
    .BLANK       (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_upd     (src_upd),
    .alert_req   (alert_req),
    .alert_data  (alert_data),
    .alert_ack   (alert_ack),
    .disp_data   (disp_data),
    .disp_we     (disp_we),
    .page_idx    (page_idx),
    .alert_active(alert_active)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  // Reference model: mode, shown page, saved page and the absolute cycle of the next timed write
  int          m_mode;
  int          m_page;
  int          m_saved;
  longint      m_deadline;
  logic [15:0] e_data;
  logic        e_we, e_ack, e_active;

  // Log of observed writes
  longint      w_cyc[$];
  logic [15:0] w_data[$];
  int          w_page[$];

  function automatic logic [15:0] src_word(int i);
    return src_data[i*DW +: DW];
  endfunction

  function automatic int rr_after(logic [N-1:0] v, int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [20:0] got_vec();
    return {disp_we, disp_data, page_idx, alert_ack, alert_active};
  endfunction

  function automatic logic [20:0] want_vec();
    return {e_we, e_data, 2'(m_page), e_ack, e_active};
  endfunction

  task automatic set_page(int i, logic [15:0] v);
    src_data[i*DW +: DW] = v;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_page = 0; m_saved = 0; m_deadline = -1;
    e_data = 16'h0000; e_we = 1'b0; e_ack = 1'b0; e_active = 1'b0;
  endtask

  // Apply the scheduling rules to the inputs of the current cycle; results show next cycle
  task automatic model_decide();
    int tgt;
    bit adv;
    e_we = 1'b0; e_ack = 1'b0; adv = 1'b0; tgt = -1;
    if (m_mode != M_ALERT && alert_req) begin
      m_saved    = m_page;
      m_mode     = M_ALERT;
      e_data     = alert_data;
      e_we       = 1'b1;
      e_ack      = 1'b1;
      e_active   = 1'b1;
      m_deadline = cyc + 1 + ALRT;
    end else begin
      if (m_mode == M_IDLE) begin
        if (src_valid != '0) begin adv = 1'b1; tgt = rr_after(src_valid, N - 1); end
      end else if (m_mode == M_SHOW) begin
        if (cyc + 1 == m_deadline || !src_valid[m_page]) begin adv = 1'b1; tgt = rr_after(src_valid, m_page); end
      end else if (cyc + 1 == m_deadline) begin
        adv = 1'b1;
        tgt = src_valid[m_saved] ? m_saved : rr_after(src_valid, m_saved);
      end
      if (adv) begin
        e_active = 1'b0;
        e_we     = 1'b1;
        if (tgt >= 0) begin
          m_mode = M_SHOW; m_page = tgt; e_data = src_word(tgt); m_deadline = cyc + 1 + DWELL;
        end else begin
          m_mode = M_IDLE; e_data = 16'h0000;
        end
      end else if (m_mode == M_SHOW && src_upd[m_page]) begin
        e_we = 1'b1; e_data = src_word(m_page);
      end
    end
  endtask

  task automatic tick();
    model_decide();
    @(posedge clk);
    #1;
    cyc++;
    if (disp_we) begin
      w_cyc.push_back(cyc); w_data.push_back(disp_data); w_page.push_back(int'(page_idx));
    end
  endtask

  task automatic clear_log();
    w_cyc.delete(); w_data.delete(); w_page.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_data = '0; src_valid = '0; src_upd = '0; alert_req = 1'b0; alert_data = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_data = '0; src_valid = '0; src_upd = '0; alert_req = 1'b0; alert_data = '0;
    @(posedge clk);
    #1;
    n_cmp++; if (disp_data !== 16'h0000) begin n_bad++; $display("FAIL reset_data got=%h want=0000", disp_data); end
    n_cmp++; if (disp_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b want=0", disp_we); end
    n_cmp++; if (page_idx !== 2'd0) begin n_bad++; $display("FAIL reset_page got=%0d want=0", page_idx); end
    n_cmp++; if (alert_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b want=0", alert_ack); end
    n_cmp++; if (alert_active !== 1'b0) begin n_bad++; $display("FAIL reset_active got=%b want=0", alert_active); end
    // Idle with nothing valid must produce no writes
    do_reset();
    repeat (5) begin
      tick();
      n_cmp++; if (got_vec() !== want_vec()) begin n_bad++; $display("FAIL idle_quiet cyc=%0d got=%h want=%h", cyc, got_vec(), want_vec()); end
    end
  endtask

  task automatic test_rotation();
    logic [15:0] exp_d [3];
    int          exp_p [3];
    exp_d = '{16'h1111, 16'h2222, 16'h1111};
    exp_p = '{0, 2, 0};
    do_reset();
    src_valid = 4'b0101; set_page(0, 16'h1111); set_page(2, 16'h2222);
    repeat (20) begin
      tick();
      n_cmp++; if (got_vec() !== want_vec()) begin n_bad++; $display("FAIL rotation cyc=%0d got=%h want=%h", cyc, got_vec(), want_vec()); end
    end
    n_cmp++;
    if (w_data.size() != 3) begin
      n_bad++; $display("FAIL rotation_count got=%0d want=3", w_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (w_data[i] !== exp_d[i] || w_page[i] != exp_p[i]) begin
          n_bad++; $display("FAIL rotation_write%0d got=%h/p%0d want=%h/p%0d", i, w_data[i], w_page[i], exp_d[i], exp_p[i]);
        end
      end
      n_cmp++; if (w_cyc[1] - w_cyc[0] != DWELL || w_cyc[2] - w_cyc[1] != DWELL) begin
        n_bad++; $display("FAIL rotation_gap got=%0d,%0d want=8,8", w_cyc[1] - w_cyc[0], w_cyc[2] - w_cyc[1]);
      end
    end
  endtask

  task automatic test_upd();
    do_reset();
    src_valid = 4'b0101; set_page(0, 16'h1111); set_page(2, 16'h2222);
    for (int t = 1; t <= 20; t++) begin
      if (t == 12) begin set_page(2, 16'h2A2A); src_upd = 4'b0100; end
      else if (t == 14) src_upd = 4'b0001;  // another source's update while page 2 is shown
      else src_upd = '0;
      tick();
      n_cmp++; if (got_vec() !== want_vec()) begin n_bad++; $display("FAIL upd cyc=%0d got=%h want=%h", cyc, got_vec(), want_vec()); end
    end
    src_upd = '0;
    n_cmp++;
    if (w_data.size() != 4) begin
      n_bad++; $display("FAIL upd_count got=%0d want=4", w_data.size());
    end else begin
      n_cmp++; if (w_data[2] !== 16'h2A2A || w_cyc[2] - w_cyc[1] != 3) begin
        n_bad++; $display("FAIL upd_write got=%h@+%0d want=2a2a@+3", w_data[2], w_cyc[2] - w_cyc[1]);
      end
      n_cmp++; if (w_data[3] !== 16'h1111 || w_cyc[3] - w_cyc[1] != DWELL) begin
        n_bad++; $display("FAIL upd_rotate got=%h@+%0d want=1111@+8", w_data[3], w_cyc[3] - w_cyc[1]);
      end
    end
  endtask

  task automatic test_alert_at_expiry();
    int act_cnt;
    act_cnt = 0;
    do_reset();
    src_valid = 4'b0101; set_page(0, 16'h1111); set_page(2, 16'h2222);
    for (int t = 1; t <= 20; t++) begin
      if (t == 9) begin alert_req = 1'b1; alert_data = 16'hEEEE; end
      tick();
      if (alert_ack) alert_req = 1'b0;
      if (alert_active) act_cnt++;
      n_cmp++; if (got_vec() !== want_vec()) begin n_bad++; $display("FAIL alert cyc=%0d got=%h want=%h", cyc, got_vec(), want_vec()); end
    end
    n_cmp++; if (act_cnt != ALRT) begin n_bad++; $display("FAIL alert_active_len got=%0d want=5", act_cnt); end
    n_cmp++;
    if (w_data.size() < 3) begin
      n_bad++; $display("FAIL alert_count got=%0d want>=3", w_data.size());
    end else begin
      n_cmp++; if (w_data[1] !== 16'hEEEE || w_cyc[1] - w_cyc[0] != DWELL) begin
        n_bad++; $display("FAIL alert_write got=%h@+%0d want=eeee@+8", w_data[1], w_cyc[1] - w_cyc[0]);
      end
      n_cmp++; if (w_data[2] !== 16'h1111 || w_page[2] != 0 || w_cyc[2] - w_cyc[1] != ALRT) begin
        n_bad++; $display("FAIL alert_return got=%h/p%0d@+%0d want=1111/p0@+5", w_data[2], w_page[2], w_cyc[2] - w_cyc[1]);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    src_valid = 4'b0100; set_page(2, 16'h2222); set_page(3, 16'h3333);
    for (int t = 1; t <= 12; t++) begin
      if (t == 4) src_valid = 4'b0000;
      if (t == 9) src_valid = 4'b1000;
      tick();
      n_cmp++; if (got_vec() !== want_vec()) begin n_bad++; $display("FAIL drop cyc=%0d got=%h want=%h", cyc, got_vec(), want_vec()); end
    end
    n_cmp++;
    if (w_data.size() != 3) begin
      n_bad++; $display("FAIL drop_count got=%0d want=3", w_data.size());
    end else begin
      n_cmp++; if (w_data[1] !== 16'h0000 || w_cyc[1] - w_cyc[0] != 3) begin
        n_bad++; $display("FAIL drop_blank got=%h@+%0d want=0000@+3", w_data[1], w_cyc[1] - w_cyc[0]);
      end
      n_cmp++; if (w_data[2] !== 16'h3333 || w_page[2] != 3) begin
        n_bad++; $display("FAIL drop_resume got=%h/p%0d want=3333/p3", w_data[2], w_page[2]);
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] d1;
    d1 = 16'($urandom);
    do_reset();
    src_valid = 4'b0010; set_page(1, d1); set_page(0, 16'($urandom));
    repeat (30) begin
      tick();
      n_cmp++; if (got_vec() !== want_vec()) begin n_bad++; $display("FAIL single cyc=%0d got=%h want=%h", cyc, got_vec(), want_vec()); end
    end
    n_cmp++;
    if (w_data.size() != 4) begin
      n_bad++; $display("FAIL single_count got=%0d want=4", w_data.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_cmp++; if (w_data[i] !== d1 || w_page[i] != 1 || w_cyc[i] - w_cyc[i-1] != DWELL) begin
          n_bad++; $display("FAIL single_write%0d got=%h/p%0d@+%0d want=%h/p1@+8", i, w_data[i], w_page[i], w_cyc[i] - w_cyc[i-1], d1);
        end
      end
    end
  endtask

  task automatic test_reset_in_alert();
    logic [15:0] d0;
    d0 = 16'($urandom);
    do_reset();
    src_valid = 4'b0001; set_page(0, d0);
    repeat (2) tick();
    alert_req = 1'b1; alert_data = 16'hBEEF;
    tick();
    alert_req = 1'b0;
    tick();
    n_cmp++; if (alert_active !== 1'b1) begin n_bad++; $display("FAIL rst_alert_pre got=%b want=1", alert_active); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (disp_data !== 16'h0000) begin n_bad++; $display("FAIL rst_alert_data got=%h want=0000", disp_data); end
    n_cmp++; if (alert_active !== 1'b0) begin n_bad++; $display("FAIL rst_alert_active got=%b want=0", alert_active); end
    n_cmp++; if (disp_we !== 1'b0 || alert_ack !== 1'b0 || page_idx !== 2'd0) begin
      n_bad++; $display("FAIL rst_alert_ctrl got=we%b ack%b p%0d want=we0 ack0 p0", disp_we, alert_ack, page_idx);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    clear_log();
    repeat (4) begin
      tick();
      n_cmp++; if (got_vec() !== want_vec()) begin n_bad++; $display("FAIL rst_restart cyc=%0d got=%h want=%h", cyc, got_vec(), want_vec()); end
    end
    n_cmp++; if (w_data.size() != 1 || w_data[0] !== d0 || w_page[0] != 0) begin
      n_bad++; $display("FAIL rst_first_write got=%0d writes want=1 write of %h", w_data.size(), d0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      src_data = {$urandom, $urandom};
      src_upd  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 11) == 0) src_valid = 4'($urandom);
      if (!alert_req && $urandom_range(0, 40) == 0) begin
        alert_req = 1'b1; alert_data = 16'($urandom);
      end
      tick();
      if (alert_ack && $urandom_range(0, 3) != 0) alert_req = 1'b0;
      n_cmp++; if (got_vec() !== want_vec()) begin n_bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, got_vec(), want_vec()); end
    end
    alert_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_upd();
    test_alert_at_expiry();
    test_drop();
    test_single();
    test_reset_in_alert();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_page_scheduler.md
# disp_page_scheduler

Controller that time-shares the 4-digit seven-segment display between up to NUM_SRC data sources. Drives the display driver's 16-bit `data_in` and `we` inputs. Rotates round-robin through the sources that currently have content, dwelling on each for DWELL_CYCLES. Lets one alert requester preempt the rotation for ALERT_CYCLES. Sits between the sensor/status producers (e.g. PMOD ALS light value, error codes) and the display driver.

## Interface
- NUM_SRC, 4, number of page sources (2..8)
- DW, 16, data width per page (4 hex digits)
- DWELL_CYCLES, 20_000_000, cycles a page is shown (2 s at 10 MHz)
- ALERT_CYCLES, 30_000_000, cycles an alert is shown
- BLANK, 16'h0000, value written when no source is valid

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- src_data  in  NUM_SRC*DW  packed page data; source i occupies [i*DW +: DW]
- src_valid  in  NUM_SRC  level; source i has content to display
- src_upd  in  NUM_SRC  1-cycle pulse; source i data changed
- alert_req  in  1  level; requester holds it until alert_ack
- alert_data  in  DW  alert page content, sampled on acceptance
- alert_ack  out  1  1-cycle pulse; alert accepted
- disp_data  out  DW  to display driver data_in
- disp_we  out  1  to display driver we, 1-cycle pulse
- page_idx  out  $clog2(NUM_SRC)  source currently shown
- alert_active  out  1  high while in ALERT

## Operation
- Reset values: state IDLE, disp_data=BLANK, disp_we=0, page_idx=0, alert_ack=0, alert_active=0, timer=0.
- States: IDLE, SHOW, ALERT.
- IDLE:
  - If any src_valid is set, select the lowest valid index, go to SHOW, write that source's data, load the dwell timer.
- SHOW (page p):
  - Dwell timer expiry: select next valid index after p, searching p+1..NUM_SRC-1 then wrapping 0..p. Write it and reload the timer.
    - If p is the only valid source, re-write p and reload.
  - src_upd[p]: re-write src_data[p]. Timer is not reloaded.
  - src_upd[j] with j≠p: ignored.
  - src_valid[p] drops: advance to the next valid source immediately.
    - If none is valid: go to IDLE and write BLANK.
- ALERT entry, from any state when alert_req=1:
  - Save p, write alert_data, pulse alert_ack, set alert_active, load ALERT_CYCLES.
- ALERT:
  - alert_req and src_upd are ignored.
  - On expiry: clear alert_active and return to saved p if src_valid[p] is still set; otherwise go to next valid or IDLE, following the SHOW rules.
  - On return, write and reload dwell.
- Priority for simultaneous events in one cycle: alert entry > advance (expiry or valid drop) > src_upd. One write per cycle maximum.
- Round-robin index arithmetic is modulo NUM_SRC. Timers are loadable down-counters sized $clog2(max(DWELL_CYCLES, ALERT_CYCLES)+1).

## Timing
- Every write is registered: a decision at cycle t gives disp_we=1 and the new disp_data at t+1. disp_data is sampled from inputs at t.
- disp_data is stable whenever disp_we=0.
- src_upd[p] at t gives a write at t+1.
- alert_req high at t gives alert_ack, disp_we and alert_data at t+1.
  - alert_req still high after ack and after ALERT exit is accepted as a new alert on the first SHOW or IDLE cycle.
- The page is displayed for exactly DWELL_CYCLES cycles between consecutive rotation writes.
- Asynchronous rst mid-operation: all outputs return to reset values immediately. The first write after release follows IDLE rules.

## Structure
- Package disp_sched_pkg:
  - state enum (IDLE, SHOW, ALERT)
  - BLANK default
  - function next_valid(valid, cur) returning the round-robin index and a found flag
- Sub-module disp_dwell_timer:
  - loadable down-counter
  - inputs: load, load_val
  - output: expire, a 1-cycle pulse when the count reaches 0
  - shared by the dwell and alert phases

## Test plan
Use NUM_SRC=4, DWELL_CYCLES=8, ALERT_CYCLES=5.
- Reset, then set src_valid=4'b0101, data0=16'h1111, data2=16'h2222. Required: writes 1111, then 2222 8 cycles later, then 1111 after another 8; page_idx goes 0,2,0.
- In SHOW on page 2, pulse src_upd[2] with data 16'h2A2A. Required: write 2A2A next cycle, and rotation still happens at the original dwell expiry.
- alert_req with alert_data=16'hEEEE in the same cycle as dwell expiry. Required: alert wins; ack and EEEE write next cycle; alert_active high for 5 cycles; then return to the saved page with a write.
- Drop src_valid[p] while showing p with no other source valid. Required: BLANK write next cycle, state IDLE; reasserting src_valid[3] gives a write of data3.
- Only src_valid[1] set. Required: data1 is re-written every 8 cycles and page_idx stays 1.
- Assert rst during ALERT. Required: disp_data=0000, alert_active=0, no we. After release, normal IDLE start.
